reorder_buffer: RTL and testbench
=================================

Name: reorder_buffer

Overview:
- Circular reorder buffer for the out-of-order core.
- Allocates one entry per issued instruction and supplies that entry index to the RS/LSB as the destination tag.
- Captures completion broadcasts from the RS (ALU) and LSB, and retires entries strictly in program order.
- Issues register-write, store-release and misprediction-flush commands at commit; the flush is the `rob_clear_up` consumed by the RS.

Parameters:
- ROB_BITS, 3, log2 of entry count (8 entries).

Ports:
- clk_in  in  1  system clock; the only clock.
- rst_in  in  1  reset; asynchronous and active-low.
- rdy_in  in  1  pause when low.
- issue_valid  in  1  decoder issues an instruction this cycle.
- issue_type  in  2  0=REG (writes rd), 1=STORE, 2=BRANCH, 3=reserved (treated as REG).
- issue_rd  in  5  destination register.
- issue_pred_pc  in  32  predicted next PC (BRANCH only).
- issue_ready  in  1  result already known at issue (lui/auipc/jal).
- issue_value  in  32  result when issue_ready=1.
- issue_entry  out  ROB_BITS  tail index; tag of the instruction issued this cycle.
- is_full  out  1  count == 2^ROB_BITS.
- rs_ready  in  1  RS/ALU broadcast valid.
- rs_rob_entry  in  ROB_BITS  RS broadcast tag.
- rs_value  in  32  result; for BRANCH, the actual next PC.
- lsb_ready  in  1  LSB broadcast valid.
- lsb_rob_entry  in  ROB_BITS  LSB broadcast tag.
- lsb_value  in  32  load result / store-done (value ignored for STORE).
- query1_entry, query2_entry  in  ROB_BITS  operand tags looked up by the decoder.
- query1_ready, query2_ready  out  1  the tagged result is available.
- query1_value, query2_value  out  32  the tagged result.
- commit_valid  out  1  one-cycle pulse: REG entry retired.
- commit_rd  out  5  retired destination.
- commit_value  out  32  retired value.
- commit_entry  out  ROB_BITS  retired tag; the regfile clears its dependency only if the tag matches.
- store_commit  out  1  one-cycle pulse: head STORE retired; the LSB may perform the write.
- rob_clear_up  out  1  one-cycle flush pulse.
- redirect_pc  out  32  correct PC, valid with rob_clear_up.

Behaviour:
- State:
  - Per-entry: busy, ready, type, rd, pred_pc, value.
  - Pointers: head and tail (ROB_BITS each, wrap modulo 2^ROB_BITS) and count (ROB_BITS+1 bits).
- Reset (rst_in=0, asynchronous):
  - head=tail=count=0; all busy/ready=0.
  - All registered outputs are 0: commit_valid, commit_rd, commit_value, commit_entry, store_commit, rob_clear_up, redirect_pc.
- rdy_in=0: no state change; the pulse outputs (commit_valid, store_commit, rob_clear_up) are registered to 0.
- Issue:
  - Condition: issue_valid && !is_full && !rob_clear_up.
  - Writes the entry at tail with busy=1, ready=issue_ready, value=issue_value; tail increments.
  - issue_valid while full, or during a rob_clear_up cycle, is ignored with no state change.
  - issue_entry = tail (combinational).
- Writeback:
  - On rs_ready, the entry at rs_rob_entry gets ready=1 and value=rs_value. lsb_ready behaves identically.
  - A tag hitting a non-busy entry is ignored.
  - RS and LSB hitting the same tag in the same cycle: LSB wins.
  - A writeback to the entry being issued in the same cycle is impossible by protocol; issue wins.
- Query (combinational, bypass), priority order:
  1. entry busy && ready → stored value;
  2. else rs_ready && tag match → rs_value;
  3. else lsb_ready && tag match → lsb_value;
  4. else ready=0, value=0.
- Commit: at most one per cycle, when head is busy && ready && !rob_clear_up. Outputs are registered and valid the cycle after the edge.
  - REG: commit_valid=1 with rd/value/entry. rd=0 is still pulsed; the regfile discards it.
  - STORE: store_commit=1.
  - BRANCH with value == pred_pc: retire silently.
  - BRANCH with value != pred_pc: rob_clear_up=1 and redirect_pc=value. At the same edge all busy flags clear and head=tail=count=0; the issue in that cycle is discarded.
  - Retiring entries clear busy, and head increments.
- Count update: count_next = count + issue_accepted − commit_done.
  - Issue and commit in the same cycle leave count unchanged.
  - is_full is evaluated on the current count, so a commit does not free a slot for a same-cycle issue.
- Latency:
  - An entry with issue_ready=1 issued into an empty ROB commits at the next edge; the pulse appears 2 cycles after issue_valid.
  - The minimum issue→commit_valid latency is 2 cycles.

Test Plan:
- Reset:
  - Stimulus: rst_in=0 mid-run with 5 busy entries.
  - Required: immediately is_full=0, commit_valid=0, rob_clear_up=0, issue_entry=0.
  - After release: the first issue gets tag 0.
- Fill and wrap:
  - Stimulus: issue 8 REG entries with no writebacks.
  - Required: is_full=1, a 9th issue_valid is ignored.
  - Then: writeback tag 0 value 0x11 → commit_valid with commit_rd=issue rd, commit_value=0x11, commit_entry=0.
  - Then: the next issue gets tag 0 (wrap).
- Out-of-order completion:
  - Stimulus: issue tags 0,1,2; writeback 2 then 1 then 0.
  - Required: no commit until tag 0 is ready, then commits 0,1,2 on consecutive cycles.
- Mispredict:
  - Stimulus: BRANCH pred_pc=0x100 at tag 0, REG at tag 1; rs_value=0x200 on tag 0.
  - Required: rob_clear_up=1, redirect_pc=0x200 for one cycle; tag 1 is never committed; the next issue gets tag 0.
- Bypass and collision:
  - Stimulus: query1_entry=3 while rs_ready on tag 3 with value 0x55.
  - Required: query1_ready=1, query1_value=0x55 in the same cycle.
  - Stimulus: simultaneous rs/lsb on tag 3 with values 0xAA and 0xBB.
  - Required: the stored value is 0xBB.
- Store and pause:
  - Stimulus: STORE at head made ready by lsb_ready.
  - Required: one store_commit pulse.
  - Stimulus: rdy_in=0 with a ready head.
  - Required: no commit, and pointers are unchanged until rdy_in=1.

Source files
------------

// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module  : reorder_buffer
// Brief   : Circular reorder buffer; allocates tags at issue, captures RS/LSB
//           completions and retires strictly in program order.
// Rev     : 1.0
// ============================================================================
module reorder_buffer #(
  parameter int ROB_BITS = 3
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic                issue_valid,
  input  logic [1:0]          issue_type,
  input  logic [4:0]          issue_rd,
  input  logic [31:0]         issue_pred_pc,
  input  logic                issue_ready,
  input  logic [31:0]         issue_value,
  output logic [ROB_BITS-1:0] issue_entry,
  output logic                is_full,
  input  logic                rs_ready,
  input  logic [ROB_BITS-1:0] rs_rob_entry,
  input  logic [31:0]         rs_value,
  input  logic                lsb_ready,
  input  logic [ROB_BITS-1:0] lsb_rob_entry,
  input  logic [31:0]         lsb_value,
  input  logic [ROB_BITS-1:0] query1_entry,
  input  logic [ROB_BITS-1:0] query2_entry,
  output logic                query1_ready,
  output logic                query2_ready,
  output logic [31:0]         query1_value,
  output logic [31:0]         query2_value,
  output logic                commit_valid,
  output logic [4:0]          commit_rd,
  output logic [31:0]         commit_value,
  output logic [ROB_BITS-1:0] commit_entry,
  output logic                store_commit,
  output logic                rob_clear_up,
  output logic [31:0]         redirect_pc
);

  localparam int         c_DEPTH    = 1 << ROB_BITS;
  localparam logic [1:0] c_T_REG    = 2'd0;
  localparam logic [1:0] c_T_STORE  = 2'd1;
  localparam logic [1:0] c_T_BRANCH = 2'd2;

  logic [c_DEPTH-1:0]  r_busy;
  logic [c_DEPTH-1:0]  r_ready;
  logic [1:0]          r_type    [c_DEPTH];
  logic [4:0]          r_rd      [c_DEPTH];
  logic [31:0]         r_pred_pc [c_DEPTH];
  logic [31:0]         r_value   [c_DEPTH];
  logic [ROB_BITS-1:0] r_head;
  logic [ROB_BITS-1:0] r_tail;
  logic [ROB_BITS:0]   r_count;

  logic                r_commit_valid;
  logic [4:0]          r_commit_rd;
  logic [31:0]         r_commit_value;
  logic [ROB_BITS-1:0] r_commit_entry;
  logic                r_store_commit;
  logic                r_rob_clear_up;
  logic [31:0]         r_redirect_pc;

  logic                w_full;
  logic                w_commit;
  logic                w_mispredict;
  logic                w_issue;
  logic [1:0]          w_head_type;
  logic [1:0]          w_issue_type;

  assign w_full       = (r_count == c_DEPTH[ROB_BITS:0]);
  assign w_head_type  = r_type[r_head];
  assign w_commit     = rdy_in && r_busy[r_head] && r_ready[r_head] && !r_rob_clear_up;
  assign w_mispredict = w_commit && (w_head_type == c_T_BRANCH) &&
                        (r_value[r_head] != r_pred_pc[r_head]);
  // The issue slot is also lost on the flush edge itself, not only while the pulse is high.
  assign w_issue      = rdy_in && issue_valid && !w_full && !r_rob_clear_up && !w_mispredict;
  assign w_issue_type = (issue_type == 2'd3) ? c_T_REG : issue_type;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_busy  <= '0;
      r_ready <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (rdy_in) begin
      if (w_mispredict) begin
        r_busy  <= '0;
        r_ready <= '0;
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (rs_ready && r_busy[rs_rob_entry])
          r_ready[rs_rob_entry] <= 1'b1;
        if (lsb_ready && r_busy[lsb_rob_entry])
          r_ready[lsb_rob_entry] <= 1'b1;
        if (w_issue) begin
          r_busy[r_tail]  <= 1'b1;
          r_ready[r_tail] <= issue_ready;
          r_tail          <= r_tail + 1'b1;
        end
        if (w_commit) begin
          r_busy[r_head]  <= 1'b0;
          r_ready[r_head] <= 1'b0;
          r_head          <= r_head + 1'b1;
        end
        r_count <= r_count + (ROB_BITS+1)'(w_issue) - (ROB_BITS+1)'(w_commit);
      end
    end
  end

  // Payload storage needs no reset: busy/ready gate every use of it.
  always_ff @(posedge clk_in) begin
    if (rdy_in && !w_mispredict) begin
      if (rs_ready && r_busy[rs_rob_entry])
        r_value[rs_rob_entry] <= rs_value;
      if (lsb_ready && r_busy[lsb_rob_entry])
        r_value[lsb_rob_entry] <= lsb_value;
      if (w_issue) begin
        r_type[r_tail]    <= w_issue_type;
        r_rd[r_tail]      <= issue_rd;
        r_pred_pc[r_tail] <= issue_pred_pc;
        r_value[r_tail]   <= issue_value;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_commit_valid <= 1'b0;
      r_commit_rd    <= '0;
      r_commit_value <= '0;
      r_commit_entry <= '0;
      r_store_commit <= 1'b0;
      r_rob_clear_up <= 1'b0;
      r_redirect_pc  <= '0;
    end else begin
      r_commit_valid <= 1'b0;
      r_store_commit <= 1'b0;
      r_rob_clear_up <= 1'b0;
      if (w_commit) begin
        case (w_head_type)
          c_T_STORE: r_store_commit <= 1'b1;
          c_T_BRANCH: begin
            if (w_mispredict) begin
              r_rob_clear_up <= 1'b1;
              r_redirect_pc  <= r_value[r_head];
            end
          end
          default: begin
            r_commit_valid <= 1'b1;
            r_commit_rd    <= r_rd[r_head];
            r_commit_value <= r_value[r_head];
            r_commit_entry <= r_head;
          end
        endcase
      end
    end
  end

  always_comb begin
    query1_ready = 1'b0;
    query1_value = '0;
    if (r_busy[query1_entry] && r_ready[query1_entry]) begin
      query1_ready = 1'b1;
      query1_value = r_value[query1_entry];
    end else if (rs_ready && (rs_rob_entry == query1_entry)) begin
      query1_ready = 1'b1;
      query1_value = rs_value;
    end else if (lsb_ready && (lsb_rob_entry == query1_entry)) begin
      query1_ready = 1'b1;
      query1_value = lsb_value;
    end
  end

  always_comb begin
    query2_ready = 1'b0;
    query2_value = '0;
    if (r_busy[query2_entry] && r_ready[query2_entry]) begin
      query2_ready = 1'b1;
      query2_value = r_value[query2_entry];
    end else if (rs_ready && (rs_rob_entry == query2_entry)) begin
      query2_ready = 1'b1;
      query2_value = rs_value;
    end else if (lsb_ready && (lsb_rob_entry == query2_entry)) begin
      query2_ready = 1'b1;
      query2_value = lsb_value;
    end
  end

  assign issue_entry  = r_tail;
  assign is_full      = w_full;
  assign commit_valid = r_commit_valid;
  assign commit_rd    = r_commit_rd;
  assign commit_value = r_commit_value;
  assign commit_entry = r_commit_entry;
  assign store_commit = r_store_commit;
  assign rob_clear_up = r_rob_clear_up;
  assign redirect_pc  = r_redirect_pc;

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module  : tb_reorder_buffer
// Brief   : Directed bench for reorder_buffer against an in-order queue model.
// Rev     : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_reorder_buffer;

  localparam int ROB_BITS = 3;
  localparam int c_DEPTH  = 8;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic        issue_valid, issue_ready;
  logic [1:0]  issue_type;
  logic [4:0]  issue_rd;
  logic [31:0] issue_pred_pc, issue_value;
  logic [2:0]  issue_entry;
  logic        is_full;
  logic        rs_ready, lsb_ready;
  logic [2:0]  rs_rob_entry, lsb_rob_entry;
  logic [31:0] rs_value, lsb_value;
  logic [2:0]  query1_entry, query2_entry;
  logic        query1_ready, query2_ready;
  logic [31:0] query1_value, query2_value;
  logic        commit_valid, store_commit, rob_clear_up;
  logic [4:0]  commit_rd;
  logic [31:0] commit_value, redirect_pc;
  logic [2:0]  commit_entry;

  reorder_buffer #(.ROB_BITS(ROB_BITS)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd),
    .issue_pred_pc(issue_pred_pc), .issue_ready(issue_ready), .issue_value(issue_value),
    .issue_entry(issue_entry), .is_full(is_full),
    .rs_ready(rs_ready), .rs_rob_entry(rs_rob_entry), .rs_value(rs_value),
    .lsb_ready(lsb_ready), .lsb_rob_entry(lsb_rob_entry), .lsb_value(lsb_value),
    .query1_entry(query1_entry), .query2_entry(query2_entry),
    .query1_ready(query1_ready), .query2_ready(query2_ready),
    .query1_value(query1_value), .query2_value(query2_value),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_value(commit_value),
    .commit_entry(commit_entry), .store_commit(store_commit),
    .rob_clear_up(rob_clear_up), .redirect_pc(redirect_pc)
  );

  always #5 clk_in = ~clk_in;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // Model: program-ordered queue of in-flight instructions, each carrying its tag.
  typedef struct {
    int          tag;
    int          typ;
    logic [4:0]  rd;
    logic [31:0] pred;
    bit          rdy;
    logic [31:0] val;
  } ent_t;

  ent_t        mq[$];
  ent_t        m_new;
  int          m_tail;
  logic        e_cv, e_sc, e_clr;
  logic [4:0]  e_crd;
  logic [31:0] e_cval, e_rpc;
  logic [2:0]  e_cent;
  logic        m_was_clr, m_commit, m_flush;
  logic [32:0] m_q1, m_q2;

  function automatic logic [32:0] model_query(input logic [2:0] tag);
    foreach (mq[i])
      if (mq[i].tag == int'(tag) && mq[i].rdy) return {1'b1, mq[i].val};
    if (rs_ready && rs_rob_entry == tag) return {1'b1, rs_value};
    if (lsb_ready && lsb_rob_entry == tag) return {1'b1, lsb_value};
    return 33'd0;
  endfunction

  always @(negedge clk_in) begin
    if (!rst_in) begin
      mq.delete();
      m_tail = 0;
      e_cv = 0; e_sc = 0; e_clr = 0; e_crd = 0; e_cval = 0; e_cent = 0; e_rpc = 0;
      check("rst_is_full", 32'(is_full), 0);
      check("rst_commit_valid", 32'(commit_valid), 0);
      check("rst_store_commit", 32'(store_commit), 0);
      check("rst_clear_up", 32'(rob_clear_up), 0);
      check("rst_issue_entry", 32'(issue_entry), 0);
    end else begin
      check("issue_entry", 32'(issue_entry), m_tail);
      check("is_full", 32'(is_full), (mq.size() == c_DEPTH) ? 1 : 0);
      m_q1 = model_query(query1_entry);
      m_q2 = model_query(query2_entry);
      check("query1_ready", 32'(query1_ready), 32'(m_q1[32]));
      check("query1_value", query1_value, m_q1[31:0]);
      check("query2_ready", 32'(query2_ready), 32'(m_q2[32]));
      check("query2_value", query2_value, m_q2[31:0]);
      check("commit_valid", 32'(commit_valid), 32'(e_cv));
      check("store_commit", 32'(store_commit), 32'(e_sc));
      check("rob_clear_up", 32'(rob_clear_up), 32'(e_clr));
      if (e_cv) begin
        check("commit_rd", 32'(commit_rd), 32'(e_crd));
        check("commit_value", commit_value, e_cval);
        check("commit_entry", 32'(commit_entry), 32'(e_cent));
      end
      if (e_clr) check("redirect_pc", redirect_pc, e_rpc);

      if (!rdy_in) begin
        e_cv = 0; e_sc = 0; e_clr = 0;
      end else begin
        m_was_clr = e_clr;
        m_commit  = 0;
        m_flush   = 0;
        e_cv = 0; e_sc = 0; e_clr = 0;
        if (mq.size() > 0 && mq[0].rdy && !m_was_clr) begin
          m_commit = 1;
          if (mq[0].typ == 1) e_sc = 1;
          else if (mq[0].typ == 2) begin
            if (mq[0].val != mq[0].pred) begin
              m_flush = 1; e_clr = 1; e_rpc = mq[0].val;
            end
          end else begin
            e_cv = 1; e_crd = mq[0].rd; e_cval = mq[0].val; e_cent = 3'(mq[0].tag);
          end
        end
        if (m_flush) begin
          mq.delete();
          m_tail = 0;
        end else begin
          foreach (mq[i])
            if (rs_ready && mq[i].tag == int'(rs_rob_entry)) begin
              mq[i].rdy = 1; mq[i].val = rs_value;
            end
          foreach (mq[i])
            if (lsb_ready && mq[i].tag == int'(lsb_rob_entry)) begin
              mq[i].rdy = 1; mq[i].val = lsb_value;
            end
          if (issue_valid && mq.size() < c_DEPTH && !m_was_clr) begin
            m_new.tag  = m_tail;
            m_new.typ  = (issue_type == 2'd3) ? 0 : int'(issue_type);
            m_new.rd   = issue_rd;
            m_new.pred = issue_pred_pc;
            m_new.rdy  = issue_ready;
            m_new.val  = issue_value;
            mq.push_back(m_new);
            m_tail = (m_tail + 1) % c_DEPTH;
          end
          if (m_commit) void'(mq.pop_front());
        end
      end
    end
  end

  task automatic clr();
    issue_valid = 0; rs_ready = 0; lsb_ready = 0;
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
    clr();
  endtask

  task automatic issue(input int t, input int rd, input logic [31:0] pred,
                       input bit rdy, input logic [31:0] v);
    issue_valid = 1; issue_type = 2'(t); issue_rd = 5'(rd);
    issue_pred_pc = pred; issue_ready = rdy; issue_value = v;
  endtask

  task automatic rs_wb(input int tag, input logic [31:0] v);
    rs_ready = 1; rs_rob_entry = 3'(tag); rs_value = v;
  endtask

  task automatic lsb_wb(input int tag, input logic [31:0] v);
    lsb_ready = 1; lsb_rob_entry = 3'(tag); lsb_value = v;
  endtask

  task automatic do_reset();
    rst_in = 0;
    #1;
    tick();
    rst_in = 1;
  endtask

  initial begin
    clr();
    rst_in = 0; rdy_in = 1;
    issue_type = 0; issue_rd = 0; issue_pred_pc = 0; issue_ready = 0; issue_value = 0;
    rs_rob_entry = 0; rs_value = 0; lsb_rob_entry = 0; lsb_value = 0;
    query1_entry = 0; query2_entry = 0;
    repeat (2) tick();
    rst_in = 1;

    // Fill to capacity, then wrap.
    for (int i = 0; i < 8; i++) begin issue(0, i + 1, 0, 0, 0); tick(); end
    check("lit_full_after_8", 32'(is_full), 1);
    check("lit_tail_wrapped", 32'(issue_entry), 0);
    issue(0, 9, 0, 0, 0); tick();
    check("lit_ninth_ignored", 32'(is_full), 1);
    rs_wb(0, 32'h11); tick();
    check("lit_no_commit_same_edge", 32'(commit_valid), 0);
    tick();
    check("lit_fill_commit_valid", 32'(commit_valid), 1);
    check("lit_fill_commit_rd", 32'(commit_rd), 1);
    check("lit_fill_commit_value", commit_value, 32'h11);
    check("lit_fill_commit_entry", 32'(commit_entry), 0);
    check("lit_wrap_tag", 32'(issue_entry), 0);
    issue(0, 20, 0, 1, 32'hC0); tick();
    for (int k = 1; k < 8; k++) begin lsb_wb(k, 32'h100 + k); tick(); end
    repeat (12) tick();
    check("lit_drained_tail", 32'(issue_entry), 1);

    // Mid-run asynchronous reset with 5 busy entries.
    for (int i = 0; i < 5; i++) begin issue(0, 3, 0, 0, 0); tick(); end
    rst_in = 0;
    #1;
    check("lit_rst_is_full", 32'(is_full), 0);
    check("lit_rst_commit_valid", 32'(commit_valid), 0);
    check("lit_rst_clear_up", 32'(rob_clear_up), 0);
    check("lit_rst_issue_entry", 32'(issue_entry), 0);
    tick(); tick();
    rst_in = 1;

    // Out-of-order completion, in-order retirement.
    issue(0, 10, 0, 0, 0);
    check("lit_first_tag_after_rst", 32'(issue_entry), 0);
    tick();
    issue(0, 11, 0, 0, 0); tick();
    issue(0, 12, 0, 0, 0); tick();
    rs_wb(2, 32'h22); tick();
    rs_wb(1, 32'h21); tick();
    tick();
    check("lit_ooo_wait", 32'(commit_valid), 0);
    rs_wb(0, 32'h20); tick();
    check("lit_ooo_wait2", 32'(commit_valid), 0);
    tick();
    check("lit_ooo_c0_entry", 32'(commit_entry), 0);
    check("lit_ooo_c0_value", commit_value, 32'h20);
    tick();
    check("lit_ooo_c1_entry", 32'(commit_entry), 1);
    check("lit_ooo_c1_valid", 32'(commit_valid), 1);
    tick();
    check("lit_ooo_c2_entry", 32'(commit_entry), 2);
    check("lit_ooo_c2_rd", 32'(commit_rd), 12);
    tick();

    // Branch mispredict flush.
    do_reset();
    issue(2, 0, 32'h100, 0, 0); tick();
    issue(0, 5, 0, 1, 32'h77); tick();
    rs_wb(0, 32'h200); tick();
    issue(0, 6, 0, 1, 32'h66); tick();
    check("lit_flush_pulse", 32'(rob_clear_up), 1);
    check("lit_flush_pc", redirect_pc, 32'h200);
    check("lit_flush_tail", 32'(issue_entry), 0);
    issue(0, 6, 0, 1, 32'h66); tick();
    check("lit_flush_one_cycle", 32'(rob_clear_up), 0);
    check("lit_flush_issue_dropped", 32'(issue_entry), 0);
    repeat (3) tick();

    // Bypass and RS/LSB collision.
    for (int i = 0; i < 4; i++) begin issue(0, i + 1, 0, 0, 0); tick(); end
    query1_entry = 3; query2_entry = 1;
    rs_wb(3, 32'h55);
    #1;
    check("lit_bypass_ready", 32'(query1_ready), 1);
    check("lit_bypass_value", query1_value, 32'h55);
    check("lit_bypass_q2_miss", 32'(query2_ready), 0);
    clr();
    rs_wb(3, 32'hAA); lsb_wb(3, 32'hBB); tick();
    check("lit_collision_value", query1_value, 32'hBB);
    rs_wb(0, 32'h30); tick();
    rs_wb(1, 32'h31); tick();
    rs_wb(2, 32'h32); tick();
    repeat (6) tick();

    // Store, correct branch, reserved type, pause.
    issue(1, 0, 0, 0, 0); tick();
    lsb_wb(4, 32'hDEAD); tick();
    tick();
    check("lit_store_pulse", 32'(store_commit), 1);
    check("lit_store_no_regcommit", 32'(commit_valid), 0);
    tick();
    check("lit_store_single", 32'(store_commit), 0);
    issue(2, 0, 32'h300, 1, 32'h300); tick();
    tick();
    check("lit_branch_ok_noflush", 32'(rob_clear_up), 0);
    issue(3, 8, 0, 1, 32'hAB); tick();
    tick();
    check("lit_type3_commit", 32'(commit_valid), 1);
    check("lit_type3_value", commit_value, 32'hAB);
    check("lit_type3_entry", 32'(commit_entry), 6);
    issue(0, 7, 0, 1, 32'h99); tick();
    rdy_in = 0;
    issue(0, 9, 0, 1, 32'h1); tick();
    check("lit_pause_no_commit", 32'(commit_valid), 0);
    check("lit_pause_tail", 32'(issue_entry), 0);
    tick(); tick();
    check("lit_pause_hold", 32'(commit_valid), 0);
    rdy_in = 1;
    tick();
    check("lit_resume_commit", 32'(commit_valid), 1);
    check("lit_resume_value", commit_value, 32'h99);
    check("lit_resume_entry", 32'(commit_entry), 7);
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
